// File: rtl/fsmc_fifo_slave.sv
// FSMC per-module slave: 4-register bank plus a show-ahead sample FIFO that the MCU
// drains through a pop-on-read DATA register, with a registered level-threshold irq.
module fsmc_fifo_slave #(
   parameter int DATA_WIDTH    = 16,
   parameter int FIFO_DEPTH    = 256,
   parameter int REG_ADDR_BITS = 2
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  cs_sel,
   input  logic                  addr_en,
   input  logic                  rd_en,
   input  logic                  wr_en,
   input  logic [DATA_WIDTH-1:0] bus_data,
   output logic [DATA_WIDTH-1:0] bus_rdata,
   input  logic                  sample_valid,
   input  logic [DATA_WIDTH-1:0] sample_data,
   output logic                  irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = PW + 1;

   localparam logic [REG_ADDR_BITS-1:0] A_CTRL   = REG_ADDR_BITS'(0);
   localparam logic [REG_ADDR_BITS-1:0] A_STATUS = REG_ADDR_BITS'(1);
   localparam logic [REG_ADDR_BITS-1:0] A_DATA   = REG_ADDR_BITS'(2);
   localparam logic [REG_ADDR_BITS-1:0] A_THRESH = REG_ADDR_BITS'(3);

   logic                     sel_q, sel_d;
   logic [REG_ADDR_BITS-1:0] addr_q, addr_d;
   logic                     prev_addr_en_q, prev_wr_en_q;
   logic                     ctrl_en_q, ctrl_en_d;
   logic [11:0]              thresh_q, thresh_d;
   logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]            count_q, count_d;
   logic                     ovf_q, ovf_d, unf_q, unf_d;
   logic [DATA_WIDTH-1:0]    rdata_q, rdata_d;
   logic                     irq_q, irq_d;
   logic [DATA_WIDTH-1:0]    mem_q [FIFO_DEPTH];

   logic addr_rise, wr_fall, mcu_wr, mcu_rd;
   logic push_req, pop_req, do_push, do_pop, fifo_clear;
   logic empty, full;
   logic [15:0] status_val;
   logic [DATA_WIDTH-1:0] head_val;

   // Upper write-data bits have no destination in the register map.
   logic unused_bus_bits;
   assign unused_bus_bits = ^bus_data[DATA_WIDTH-1:12];

   assign addr_rise  = addr_en & ~prev_addr_en_q;
   assign wr_fall    = prev_wr_en_q & ~wr_en;
   // cs_sel is only valid at the address edge; later strobes rely on sel_q.
   assign mcu_wr     = rd_en & sel_q;
   assign mcu_rd     = wr_fall & sel_q;
   assign empty      = (count_q == '0);
   assign full       = (count_q == CW'(FIFO_DEPTH));
   assign push_req   = sample_valid & ctrl_en_q;
   assign pop_req    = mcu_rd & (addr_q == A_DATA);
   assign do_pop     = pop_req & ~empty;
   assign do_push    = push_req & (~full | do_pop);
   assign fifo_clear = mcu_wr & (addr_q == A_CTRL) & bus_data[1];

   assign status_val = {unf_q, ovf_q, full, empty, 12'(count_q)};
   assign head_val   = empty ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      sel_d     = sel_q;
      addr_d    = addr_q;
      ctrl_en_d = ctrl_en_q;
      thresh_d  = thresh_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ovf_d     = ovf_q;
      unf_d     = unf_q;
      rdata_d   = '0;

      if (mcu_wr || mcu_rd) sel_d = 1'b0;
      if (addr_rise) begin
         sel_d = cs_sel;
         if (cs_sel) addr_d = bus_data[REG_ADDR_BITS-1:0];
      end

      if (mcu_wr) begin
         if (addr_q == A_CTRL)   ctrl_en_d = bus_data[0];
         if (addr_q == A_THRESH) thresh_d  = bus_data[11:0];
      end

      if (fifo_clear) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         ovf_d    = 1'b0;
         unf_d    = 1'b0;
      end else begin
         if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
         if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
         count_d = count_q + CW'(do_push) - CW'(do_pop);
         if (push_req && !do_push) ovf_d = 1'b1;
         if (pop_req && empty)     unf_d = 1'b1;
      end

      if (sel_q) begin
         case (addr_q)
            A_CTRL:   rdata_d = DATA_WIDTH'(ctrl_en_q);
            A_STATUS: rdata_d = DATA_WIDTH'(status_val);
            A_DATA:   rdata_d = head_val;
            A_THRESH: rdata_d = DATA_WIDTH'(thresh_q);
            default:  rdata_d = '0;
         endcase
      end

      irq_d = ctrl_en_d & (thresh_d != '0) & (12'(count_d) >= thresh_d);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sel_q          <= 1'b0;
         addr_q         <= '0;
         prev_addr_en_q <= 1'b0;
         prev_wr_en_q   <= 1'b0;
         ctrl_en_q      <= 1'b0;
         thresh_q       <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         count_q        <= '0;
         ovf_q          <= 1'b0;
         unf_q          <= 1'b0;
         rdata_q        <= '0;
         irq_q          <= 1'b0;
      end else begin
         sel_q          <= sel_d;
         addr_q         <= addr_d;
         prev_addr_en_q <= addr_en;
         prev_wr_en_q   <= wr_en;
         ctrl_en_q      <= ctrl_en_d;
         thresh_q       <= thresh_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         count_q        <= count_d;
         ovf_q          <= ovf_d;
         unf_q          <= unf_d;
         rdata_q        <= rdata_d;
         irq_q          <= irq_d;
      end
   end

   // Sample storage carries no reset; only the pointers define its contents.
   always_ff @(posedge clk) begin
      if (do_push && !fifo_clear) mem_q[wr_ptr_q] <= sample_data;
   end

   assign bus_rdata = rdata_q;
   assign irq       = irq_q;

endmodule

// File: tb/tb_fsmc_fifo_slave.sv
// Bench for fsmc_fifo_slave: bus driver tasks, sample queue scoreboard, register model.
module tb_fsmc_fifo_slave;

   localparam int DW    = 16;
   localparam int DEPTH = 256;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          cs_sel, addr_en, rd_en, wr_en;
   logic [DW-1:0] bus_data, bus_rdata;
   logic          sample_valid;
   logic [DW-1:0] sample_data;
   logic          irq;

   fsmc_fifo_slave #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .REG_ADDR_BITS(2)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .cs_sel      (cs_sel),
      .addr_en     (addr_en),
      .rd_en       (rd_en),
      .wr_en       (wr_en),
      .bus_data    (bus_data),
      .bus_rdata   (bus_rdata),
      .sample_valid(sample_valid),
      .sample_data (sample_data),
      .irq         (irq)
   );

   always #5 clk = ~clk;

   int check_cnt = 0;
   int err_cnt   = 0;

   logic [DW-1:0] exp_q[$];
   logic          m_en, m_ovf, m_unf;
   logic [11:0]   m_thresh;
   logic [DW-1:0] rd_val;

   task automatic check_eq(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      check_cnt++;
      if (act !== exp) begin
         err_cnt++;
         $display("FAIL %s actual=0x%h expected=0x%h", tag, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] m_status();
      int n;
      n = exp_q.size();
      return {m_unf, m_ovf, (n == DEPTH), (n == 0), 12'(n)};
   endfunction

   function automatic void m_reset();
      exp_q.delete();
      m_en = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_thresh = '0;
   endfunction

   function automatic void m_push(input logic [DW-1:0] v);
      if (m_en) begin
         if (exp_q.size() < DEPTH) exp_q.push_back(v);
         else                      m_ovf = 1'b1;
      end
   endfunction

   task automatic bus_addr(input logic cs, input logic [DW-1:0] a);
      @(negedge clk);
      addr_en = 1'b1; cs_sel = cs; bus_data = a;
      @(negedge clk);
      addr_en = 1'b0; cs_sel = 1'b0;
   endtask

   task automatic bus_write(input logic cs, input logic [DW-1:0] a, input logic [DW-1:0] d);
      bus_addr(cs, a);
      rd_en = 1'b1; bus_data = d;
      @(negedge clk);
      rd_en = 1'b0; bus_data = '0;
      if (cs) begin
         if (a == 0) begin
            m_en = d[0];
            if (d[1]) begin
               exp_q.delete(); m_ovf = 1'b0; m_unf = 1'b0;
            end
         end
         if (a == 3) m_thresh = d[11:0];
      end
   endtask

   task automatic bus_read(input logic [DW-1:0] a, output logic [DW-1:0] d,
                           input logic push_at_end, input logic [DW-1:0] pv);
      bus_addr(1'b1, a);
      wr_en = 1'b1;
      @(negedge clk);
      d = bus_rdata;
      wr_en = 1'b0;
      if (push_at_end) begin
         sample_valid = 1'b1; sample_data = pv;
      end
      @(negedge clk);
      sample_valid = 1'b0;
      @(negedge clk);
   endtask

   task automatic read_data(input string tag, input logic push_at_end, input logic [DW-1:0] pv);
      logic [DW-1:0] exp;
      bus_read(2, rd_val, push_at_end, pv);
      if (exp_q.size() > 0) exp = exp_q.pop_front();
      else begin
         exp = '0; m_unf = 1'b1;
      end
      if (push_at_end) m_push(pv);
      check_eq(tag, rd_val, exp);
   endtask

   task automatic read_status(input string tag);
      bus_read(1, rd_val, 1'b0, '0);
      check_eq(tag, rd_val, m_status());
   endtask

   task automatic push_one(input logic [DW-1:0] v);
      @(negedge clk);
      sample_valid = 1'b1; sample_data = v;
      @(negedge clk);
      sample_valid = 1'b0;
      m_push(v);
   endtask

   initial begin
      reset_n = 1'b0; cs_sel = 1'b0; addr_en = 1'b0; rd_en = 1'b0; wr_en = 1'b0;
      bus_data = '0; sample_valid = 1'b0; sample_data = '0;
      m_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_rdata", bus_rdata, '0);
      check_eq("rst_irq", DW'(irq), '0);
      reset_n = 1'b1;

      read_status("status_after_reset");
      check_eq("status_after_reset_lit", rd_val, 16'h1000);
      check_eq("irq_after_reset", DW'(irq), '0);

      bus_write(1'b1, 0, 16'h0001);
      push_one(16'hA001); push_one(16'hA002); push_one(16'hA003);
      read_data("data_a001", 1'b0, '0);
      read_data("data_a002", 1'b0, '0);
      read_data("data_a003", 1'b0, '0);
      read_status("status_drained");

      @(negedge clk);
      for (int i = 0; i < DEPTH + 2; i++) begin
         sample_valid = 1'b1;
         sample_data  = DW'($urandom_range(0, 16'hFFFF));
         m_push(sample_data);
         @(negedge clk);
      end
      sample_valid = 1'b0;
      read_status("status_full_ovf");
      check_eq("status_full_ovf_lit", rd_val, 16'h6100);
      read_data("data_first_of_burst", 1'b0, '0);

      bus_write(1'b1, 0, 16'h0003);
      read_status("status_after_clear");
      read_data("data_empty", 1'b0, '0);
      read_status("status_underflow");
      check_eq("status_underflow_lit", rd_val, 16'h9000);
      bus_write(1'b1, 0, 16'h0003);
      read_status("status_clear_unf");
      check_eq("status_clear_unf_lit", rd_val, 16'h1000);
      bus_read(0, rd_val, 1'b0, '0);
      check_eq("ctrl_en_kept", rd_val, DW'(m_en));

      bus_write(1'b1, 3, 16'h0004);
      bus_read(3, rd_val, 1'b0, '0);
      check_eq("thresh_rb", rd_val, DW'(m_thresh));
      for (int i = 0; i < 3; i++) push_one(DW'($urandom_range(0, 16'hFFFF)));
      check_eq("irq_below_thresh", DW'(irq), '0);
      push_one(16'hB004);
      check_eq("irq_at_thresh", DW'(irq), 16'd1);
      read_data("data_irq_drain", 1'b0, '0);
      check_eq("irq_after_drain", DW'(irq), '0);

      bus_write(1'b0, 0, 16'h0003);
      bus_read(0, rd_val, 1'b0, '0);
      check_eq("ctrl_unsel_write", rd_val, 16'h0001);
      read_status("status_unsel_write");

      push_one(16'hC001); push_one(16'hC002);
      check_eq("irq_count5", DW'(irq), 16'd1);
      read_data("data_push_pop", 1'b1, 16'hC0DE);
      read_status("status_push_pop");
      check_eq("count_push_pop", rd_val & 16'h0FFF, 16'd5);

      bus_addr(1'b1, 2);
      wr_en = 1'b1;
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b0; wr_en = 1'b0;
      #1;
      check_eq("midrd_rst_rdata", bus_rdata, '0);
      check_eq("midrd_rst_irq", DW'(irq), '0);
      m_reset();
      @(negedge clk);
      reset_n = 1'b1;
      read_status("status_post_rst");
      bus_read(0, rd_val, 1'b0, '0);
      check_eq("ctrl_post_rst", rd_val, '0);

      $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
      $finish;
   end

endmodule
